// File: rtl/serial_bus_arbiter_rr.sv
// serial_bus_arbiter_rr
// Round-robin arbiter for the 1-bit serial system bus. It grants one master at
// a time. It consumes the first SEL_BITS serial address bits as a slave select
// prefix. Unmapped prefixes are NACKed. Once the selected slave is ready, the
// rest of the transaction is routed combinationally between the granted master
// and the selected slave. A ROUTE transaction with no activity for TIMEOUT
// cycles is force-released.
// Ports:
//   clk, rstn                          clock, synchronous active-low reset
//   m_req/m_mode/m_wr_bus/
//   m_master_valid/m_master_ready      per-master inputs
//   m_grant/m_ack                      registered per-master grant / ack pulse
//   m_rd_bus/m_slave_ready/
//   m_slave_valid                      routed slave responses (combinational)
//   s_mode/s_wr_bus/s_master_valid/
//   s_master_ready                     routed master signals (combinational)
//   s_rd_bus/s_slave_ready/
//   s_slave_valid                      per-slave responses
//   grant_id                           index of the granted master
//   timeout_err, nack_err              one-cycle error pulses
module serial_bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned SEL_BITS    = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_grant,
  input  logic [NUM_MASTERS-1:0] m_mode,
  input  logic [NUM_MASTERS-1:0] m_wr_bus,
  input  logic [NUM_MASTERS-1:0] m_master_valid,
  input  logic [NUM_MASTERS-1:0] m_master_ready,
  output logic [NUM_MASTERS-1:0] m_rd_bus,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  output logic [NUM_MASTERS-1:0] m_ack,
  output logic [NUM_SLAVES-1:0]  s_mode,
  output logic [NUM_SLAVES-1:0]  s_wr_bus,
  output logic [NUM_SLAVES-1:0]  s_master_valid,
  output logic [NUM_SLAVES-1:0]  s_master_ready,
  input  logic [NUM_SLAVES-1:0]  s_rd_bus,
  input  logic [NUM_SLAVES-1:0]  s_slave_ready,
  input  logic [NUM_SLAVES-1:0]  s_slave_valid,
  output logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] grant_id,
  output logic                   timeout_err,
  output logic                   nack_err
);

  localparam int unsigned GID_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned PCNT_W = $clog2(SEL_BITS + 1);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SEL_BITS:0] NS_LIM = (SEL_BITS + 1)'(NUM_SLAVES);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_ACK, S_ROUTE, S_NACK} state_t;

  state_t                   r_state, w_state_next;
  logic [NUM_MASTERS-1:0]   r_grant, r_m_ack;
  logic [GID_W-1:0]         r_gid, r_last, w_arb_idx;
  logic [SEL_W-1:0]         r_sel;
  logic [SEL_BITS-1:0]      r_prefix, w_prefix_next;
  logic [PCNT_W-1:0]        r_pcnt;
  logic [TCNT_W-1:0]        r_inact;
  logic                     r_timeout_err, r_nack_err;
  logic                     w_arb_found, w_release, w_last_bit, w_prefix_ok;
  logic                     w_idle_cyc, w_timeout, w_ack_fire, w_ack_done;

  // Round-robin search starting one past the last owner
  always_comb begin
    int unsigned idx;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = (32'(r_last) + 32'd1 + i) % NUM_MASTERS;
      if (!w_arb_found && m_req[GID_W'(idx)]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = GID_W'(idx);
      end
    end
  end

  assign w_release     = (r_state != S_IDLE) && !m_req[r_gid];
  assign w_prefix_next = SEL_BITS'({r_prefix, m_wr_bus[r_gid]});
  assign w_prefix_ok   = {1'b0, w_prefix_next} < NS_LIM;
  assign w_last_bit    = (r_state == S_CAPTURE) && m_master_valid[r_gid] &&
                         (r_pcnt == PCNT_W'(SEL_BITS - 1));
  assign w_idle_cyc    = !m_master_valid[r_gid] && !s_slave_valid[r_sel];
  assign w_timeout     = (r_state == S_ROUTE) && !w_release && w_idle_cyc &&
                         (r_inact == TCNT_W'(TIMEOUT - 1));
  assign w_ack_done    = |r_m_ack;
  // Ack pulses once; ROUTE starts the cycle after the pulse
  assign w_ack_fire    = (r_state == S_ACK) && !w_ack_done && !w_release &&
                         s_slave_ready[r_sel];

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; owner release overrides every other transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_arb_found) w_state_next = S_CAPTURE;
      S_CAPTURE: if (w_last_bit)  w_state_next = w_prefix_ok ? S_ACK : S_NACK;
      S_ACK:     if (w_ack_done)  w_state_next = S_ROUTE;
      S_ROUTE:   if (w_timeout)   w_state_next = S_IDLE;
      S_NACK:    w_state_next = S_NACK;
      default:   w_state_next = S_IDLE;
    endcase
    if (w_release) w_state_next = S_IDLE;
  end

  // Grant, prefix, select, inactivity and pulse registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_grant       <= '0;
      r_m_ack       <= '0;
      r_gid         <= '0;
      r_last        <= GID_W'(NUM_MASTERS - 1);
      r_sel         <= '0;
      r_prefix      <= '0;
      r_pcnt        <= '0;
      r_inact       <= '0;
      r_timeout_err <= 1'b0;
      r_nack_err    <= 1'b0;
    end else begin
      r_m_ack       <= w_ack_fire ? r_grant : '0;
      r_nack_err    <= (r_state == S_CAPTURE) && (w_state_next == S_NACK);
      r_timeout_err <= w_timeout;
      if (r_state == S_IDLE) begin
        if (w_arb_found) begin
          r_grant  <= NUM_MASTERS'(1) << w_arb_idx;
          r_gid    <= w_arb_idx;
          r_prefix <= '0;
          r_pcnt   <= '0;
          r_inact  <= '0;
        end
      end else if (w_state_next == S_IDLE) begin
        r_grant <= '0;
        r_last  <= r_gid;
        r_inact <= '0;
      end else begin
        if ((r_state == S_CAPTURE) && m_master_valid[r_gid]) begin
          r_prefix <= w_prefix_next;
          r_pcnt   <= r_pcnt + PCNT_W'(1);
          if (w_last_bit) r_sel <= SEL_W'(w_prefix_next);
        end
        if (r_state == S_ROUTE)
          r_inact <= w_idle_cyc ? r_inact + TCNT_W'(1) : '0;
      end
    end
  end

  // Combinational routing between owner and selected slave while in ROUTE
  always_comb begin
    m_rd_bus       = '0;
    m_slave_ready  = '0;
    m_slave_valid  = '0;
    s_mode         = '0;
    s_wr_bus       = '0;
    s_master_valid = '0;
    s_master_ready = '0;
    if (r_state == S_ROUTE) begin
      s_mode[r_sel]         = m_mode[r_gid];
      s_wr_bus[r_sel]       = m_wr_bus[r_gid];
      s_master_valid[r_sel] = m_master_valid[r_gid];
      s_master_ready[r_sel] = m_master_ready[r_gid];
      m_rd_bus[r_gid]       = s_rd_bus[r_sel];
      m_slave_ready[r_gid]  = s_slave_ready[r_sel];
      m_slave_valid[r_gid]  = s_slave_valid[r_sel];
    end
  end

  assign m_grant     = r_grant;
  assign m_ack       = r_m_ack;
  assign grant_id    = r_gid;
  assign timeout_err = r_timeout_err;
  assign nack_err    = r_nack_err;

endmodule

// File: tb/tb_serial_bus_arbiter_rr.sv
// Testbench for serial_bus_arbiter_rr: two masters and four behavioural slaves
// (12-bit address, 8-bit data). Read data is checked through a scoreboard queue.
module tb_serial_bus_arbiter_rr;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int TO = 255;

  logic          clk, rstn;
  logic [NM-1:0] m_req, m_grant, m_mode, m_wr_bus, m_master_valid, m_master_ready;
  logic [NM-1:0] m_rd_bus, m_slave_ready, m_slave_valid, m_ack;
  logic [NS-1:0] s_mode, s_wr_bus, s_master_valid, s_master_ready;
  logic [NS-1:0] s_rd_bus, s_slave_ready, s_slave_valid;
  logic [0:0]    grant_id;
  logic          timeout_err, nack_err;

  int errors = 0;
  int checks = 0;
  int multi_grant = 0;
  int sv_cnt [NS] = '{default: 0};
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  serial_bus_arbiter_rr #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SEL_BITS(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m_req(m_req), .m_grant(m_grant), .m_mode(m_mode), .m_wr_bus(m_wr_bus),
    .m_master_valid(m_master_valid), .m_master_ready(m_master_ready),
    .m_rd_bus(m_rd_bus), .m_slave_ready(m_slave_ready),
    .m_slave_valid(m_slave_valid), .m_ack(m_ack),
    .s_mode(s_mode), .s_wr_bus(s_wr_bus), .s_master_valid(s_master_valid),
    .s_master_ready(s_master_ready), .s_rd_bus(s_rd_bus),
    .s_slave_ready(s_slave_ready), .s_slave_valid(s_slave_valid),
    .grant_id(grant_id), .timeout_err(timeout_err), .nack_err(nack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slaves: write = 12 addr + 8 data bits, read = 12 addr bits then 8 bits out
  logic [19:0] sl_sr   [NS];
  int          sl_cnt  [NS];
  int          sl_tx   [NS];
  bit          sl_send [NS];
  logic [7:0]  sl_byte [NS];
  logic [7:0]  smem    [NS][4096];

  always @(posedge clk) begin
    logic [11:0] a;
    for (int j = 0; j < NS; j++) begin
      if (!rstn || m_grant == '0) begin
        sl_cnt[j] <= 0; sl_send[j] <= 1'b0; sl_tx[j] <= 0;
        s_slave_valid[j] <= 1'b0; s_rd_bus[j] <= 1'b0;
      end else if (sl_send[j]) begin
        if (s_master_ready[j]) begin
          if (sl_tx[j] == 7) begin
            sl_send[j] <= 1'b0; s_slave_valid[j] <= 1'b0; s_rd_bus[j] <= 1'b0;
          end else begin
            sl_tx[j] <= sl_tx[j] + 1;
            s_rd_bus[j] <= sl_byte[j][6 - sl_tx[j]];
          end
        end
      end else if (s_master_valid[j]) begin
        sl_sr[j]  <= {sl_sr[j][18:0], s_wr_bus[j]};
        sl_cnt[j] <= sl_cnt[j] + 1;
        if (!s_mode[j] && sl_cnt[j] == 11) begin
          a = {sl_sr[j][10:0], s_wr_bus[j]};
          sl_byte[j] <= smem[j][a];
          s_rd_bus[j] <= smem[j][a][7];
          s_slave_valid[j] <= 1'b1;
          sl_send[j] <= 1'b1; sl_tx[j] <= 0; sl_cnt[j] <= 0;
        end else if (s_mode[j] && sl_cnt[j] == 19) begin
          a = sl_sr[j][18:7];
          smem[j][a] <= {sl_sr[j][6:0], s_wr_bus[j]};
          sl_cnt[j] <= 0;
        end
      end
    end
  end

  always @(posedge clk)
    for (int j = 0; j < NS; j++) if (s_master_valid[j] === 1'b1) sv_cnt[j] <= sv_cnt[j] + 1;

  always @(negedge clk)
    if ($countones(m_grant) > 1 ||
        (m_grant != '0 && m_grant != (NM'(1) << grant_id))) multi_grant++;

  task automatic drive_bit(input int mi, input logic b);
    m_wr_bus[mi] = b; m_master_valid[mi] = 1'b1;
    @(negedge clk);
  endtask

  // Request, wait for grant, send prefix, wait for ack; returns in first ROUTE cycle
  task automatic open_txn(input int mi, input bit wr, input logic [3:0] pfx, output bit ok);
    int n;
    ok = 1'b0;
    m_req[mi] = 1'b1; m_mode[mi] = wr;
    n = 0;
    while (m_grant[mi] !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL grant_wait m%0d: no grant after %0d cycles, required grant", mi, n);
      return;
    end
    for (int b = 3; b >= 0; b--) drive_bit(mi, pfx[b]);
    m_master_valid[mi] = 1'b0;
    n = 0;
    while (m_ack[mi] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ack_wait m%0d: no m_ack after %0d cycles, required pulse", mi, n);
      return;
    end
    @(negedge clk);
    ok = 1'b1;
  endtask

  task automatic close_txn(input int mi);
    m_master_valid[mi] = 1'b0; m_master_ready[mi] = 1'b0;
    m_req[mi] = 1'b0; m_mode[mi] = 1'b0; m_wr_bus[mi] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_txn(input int mi, input bit wr, input logic [3:0] pfx,
                        input logic [11:0] addr, input logic [7:0] wdata,
                        output logic [7:0] rdata, output bit ok);
    int n, cnt;
    rdata = '0;
    open_txn(mi, wr, pfx, ok);
    if (ok) begin
      for (int b = 11; b >= 0; b--) drive_bit(mi, addr[b]);
      if (wr) for (int b = 7; b >= 0; b--) drive_bit(mi, wdata[b]);
      m_master_valid[mi] = 1'b0;
      if (!wr) begin
        m_master_ready[mi] = 1'b1;
        n = 0; cnt = 0;
        while (cnt < 8 && n < 64) begin
          if (m_slave_valid[mi] === 1'b1) begin rdata = {rdata[6:0], m_rd_bus[mi]}; cnt++; end
          n++;
          @(negedge clk);
        end
        if (cnt < 8) begin
          checks++; errors++; ok = 1'b0;
          $display("FAIL rd_bits m%0d: got %0d bits, required 8", mi, cnt);
        end
      end
    end
    close_txn(mi);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_grant !== 2'b00 || grant_id !== 1'b0) begin
      errors++; $display("FAIL reset_grant: got %b/%b, required 00/0", m_grant, grant_id);
    end
    checks++;
    if ({m_ack, m_rd_bus, m_slave_ready, m_slave_valid, s_mode, s_wr_bus, s_master_valid,
         s_master_ready, timeout_err, nack_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int snap [NS];
    logic [7:0] rd, exp_v;
    bit ok;
    for (int j = 0; j < NS; j++) snap[j] = sv_cnt[j];
    do_txn(0, 1'b1, 4'b0001, 12'h123, 8'hA5, rd, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_wr_ack: ok=%0d, required 1", ok); end
    checks++;
    if (sv_cnt[1] - snap[1] !== 20) begin
      errors++; $display("FAIL single_slave1_bits: got %0d, required 20", sv_cnt[1] - snap[1]);
    end
    checks++;
    if ((sv_cnt[0] - snap[0]) + (sv_cnt[2] - snap[2]) + (sv_cnt[3] - snap[3]) !== 0) begin
      errors++; $display("FAIL single_other_slaves: got %0d valid bits, required 0",
                         (sv_cnt[0] - snap[0]) + (sv_cnt[2] - snap[2]) + (sv_cnt[3] - snap[3]));
    end
    exp_q0.push_back(8'hA5);
    do_txn(0, 1'b0, 4'b0001, 12'h123, 8'h00, rd, ok);
    exp_v = exp_q0.pop_front();
    checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL single_readback: got %h, required %h", rd, exp_v); end
  endtask

  task automatic test_round_robin();
    rstn = 1'b0; repeat (2) @(negedge clk); rstn = 1'b1;
    m_req = 2'b11; @(negedge clk);
    checks++;
    if (m_grant !== 2'b01 || grant_id !== 1'b0) begin
      errors++; $display("FAIL rr_first: got %b/%b, required 01/0", m_grant, grant_id);
    end
    m_req[0] = 1'b0; @(negedge clk);
    checks++;
    if (m_grant !== 2'b00) begin errors++; $display("FAIL rr_gap: got %b, required 00", m_grant); end
    @(negedge clk);
    checks++;
    if (m_grant !== 2'b10 || grant_id !== 1'b1) begin
      errors++; $display("FAIL rr_second: got %b/%b, required 10/1", m_grant, grant_id);
    end
    m_req[1] = 1'b0; @(negedge clk);
    checks++;
    if (m_grant !== 2'b00) begin errors++; $display("FAIL rr_release: got %b, required 00", m_grant); end
    m_req = 2'b11; @(negedge clk);
    checks++;
    if (m_grant !== 2'b01) begin errors++; $display("FAIL rr_third: got %b, required 01", m_grant); end
    m_req = 2'b00; repeat (2) @(negedge clk);
  endtask

  task automatic test_nack();
    int snap [NS];
    int n_nack, n_ack, delta;
    snap = sv_cnt; n_nack = 0; n_ack = 0;
    m_req[0] = 1'b1; m_mode[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (m_grant !== 2'b01) begin errors++; $display("FAIL nack_grant: got %b, required 01", m_grant); end
    for (int b = 3; b >= 0; b--) drive_bit(0, b != 3);
    m_master_valid[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (nack_err === 1'b1) n_nack++;
      if (m_ack !== 2'b00) n_ack++;
      @(negedge clk);
    end
    checks++;
    if (n_nack !== 1) begin errors++; $display("FAIL nack_pulse: got %0d cycles, required 1", n_nack); end
    checks++;
    if (n_ack !== 0) begin errors++; $display("FAIL nack_no_ack: got %0d cycles, required 0", n_ack); end
    delta = 0;
    for (int j = 0; j < NS; j++) delta += sv_cnt[j] - snap[j];
    checks++;
    if (delta !== 0) begin errors++; $display("FAIL nack_no_slave: got %0d, required 0", delta); end
    checks++;
    if (m_grant !== 2'b01) begin errors++; $display("FAIL nack_hold: got %b, required 01", m_grant); end
    close_txn(0);
    checks++;
    if (m_grant !== 2'b00) begin errors++; $display("FAIL nack_release: got %b, required 00", m_grant); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    open_txn(0, 1'b1, 4'b0010, ok);
    m_req[1] = 1'b1;
    n = 1;
    while (timeout_err !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (!ok || n - 1 !== TO) begin
      errors++; $display("FAIL timeout_cycles: got %0d idle cycles (ok=%0d), required %0d", n - 1, ok, TO);
    end
    checks++;
    if (m_grant !== 2'b00) begin errors++; $display("FAIL timeout_drop: got %b, required 00", m_grant); end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || m_grant !== 2'b10 || grant_id !== 1'b1) begin
      errors++; $display("FAIL timeout_next: got err=%b grant=%b id=%b, required 0/10/1",
                         timeout_err, m_grant, grant_id);
    end
    m_req = 2'b00; m_mode = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_route();
    bit ok;
    open_txn(0, 1'b1, 4'b0010, ok);
    for (int b = 0; b < 5; b++) drive_bit(0, b[0]);
    checks++;
    if (!ok || s_master_valid !== 4'b0100) begin
      errors++; $display("FAIL rst_route_live: got %b (ok=%0d), required 0100", s_master_valid, ok);
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_grant, grant_id, m_ack, m_rd_bus, m_slave_ready, m_slave_valid, s_mode, s_wr_bus,
         s_master_valid, s_master_ready, timeout_err, nack_err} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: grant=%b smv=%b msr=%b, required all 0",
                         m_grant, s_master_valid, m_slave_ready);
    end
    rstn = 1'b1; m_req = 2'b00; m_master_valid = 2'b00; m_mode = 2'b00;
    @(negedge clk);
    m_req[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (m_grant !== 2'b01 || grant_id !== 1'b0) begin
      errors++; $display("FAIL rst_regrant: got %b/%b, required 01/0", m_grant, grant_id);
    end
    m_req = 2'b00; repeat (2) @(negedge clk);
  endtask

  task automatic master_run(input int mi);
    logic [11:0] addr;
    logic [7:0] data, rd, exp_v;
    logic [3:0] pfx;
    bit ok;
    for (int k = 0; k < 200; k++) begin
      pfx  = 4'(k % 4);
      addr = {mi[0], 11'($urandom)};
      data = 8'($urandom);
      do_txn(mi, 1'b1, pfx, addr, data, rd, ok);
      if (mi == 0) exp_q0.push_back(data); else exp_q1.push_back(data);
      do_txn(mi, 1'b0, pfx, addr, 8'h00, rd, ok);
      exp_v = (mi == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL rand_readback m%0d k=%0d s=%0d a=%h: got %h, required %h",
                 mi, k, pfx, addr, rd, exp_v);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_random();
    multi_grant = 0;
    fork
      master_run(0);
      master_run(1);
    join
    checks++;
    if (multi_grant !== 0) begin
      errors++; $display("FAIL rand_onehot: got %0d bad grant cycles, required 0", multi_grant);
    end
  endtask

  initial begin
    rstn = 1'b0;
    m_req = '0; m_mode = '0; m_wr_bus = '0; m_master_valid = '0; m_master_ready = '0;
    s_slave_ready = '1;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_nack();
    test_timeout();
    test_reset_mid_route();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
